// File: rtl/cpi_pkg.sv
// ---------------------------------------------------------------------------
// cpi_pkg : shared types for the CPI pixel packer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpi_pkg;

  typedef enum logic {
    PIX16 = 1'b0,
    PIX8  = 1'b1
  } cpi_pix_fmt_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2
  } cpi_pack_state_e;

  // Index of the lane that completes a 32-bit word for the given format.
  function automatic logic [1:0] cpi_last_lane(input cpi_pix_fmt_e fmt);
    return (fmt == PIX8) ? 2'd3 : 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpi_pack_fifo.sv
// ---------------------------------------------------------------------------
// cpi_pack_fifo : synchronous FIFO with sync clear; push while full is legal only with a pop
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cpi_pack_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign data_o    = mem_q[rd_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (w_do_pop) rd_q <= rd_q + AW'(1);
      if (w_do_push && !w_do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpi_pixel_packer.sv
// ---------------------------------------------------------------------------
// cpi_pixel_packer : frame skip, window crop and 32-bit packing of CPI pixels
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cpi_pixel_packer
  import cpi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_W      = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_en_i,
  input  logic             cfg_fmt_i,
  input  logic [5:0]       cfg_frame_skip_i,
  input  logic [CNT_W-1:0] cfg_row_len_i,
  input  logic             cfg_win_en_i,
  input  logic [CNT_W-1:0] cfg_win_ll_x_i,
  input  logic [CNT_W-1:0] cfg_win_ll_y_i,
  input  logic [CNT_W-1:0] cfg_win_ur_x_i,
  input  logic [CNT_W-1:0] cfg_win_ur_y_i,
  input  logic [PIX_W-1:0] pix_data_i,
  input  logic             pix_valid_i,
  input  logic             pix_sof_i,
  output logic [31:0]      data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             evt_sof_o,
  output logic             evt_ovf_o,
  output logic             overflow_o
);

  cpi_pack_state_e state_q, state_d;
  logic [5:0]       frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      acc_q, acc_d;
  logic             evt_sof_q, evt_sof_d;
  logic             evt_ovf_q;
  logic             overflow_q;

  cpi_pix_fmt_e     w_fmt;
  logic             w_sof;
  logic [CNT_W-1:0] w_cur_x, w_cur_y;
  logic             w_win_ok;
  logic             w_keep;
  logic [31:0]      w_acc_base;
  logic [1:0]       w_lane_base;
  logic [31:0]      w_ins;
  logic             w_push;
  logic [31:0]      w_push_data;
  logic             w_full, w_empty, w_pop, w_drop;

  assign w_fmt   = cpi_pix_fmt_e'(cfg_fmt_i);
  assign w_sof   = pix_valid_i && pix_sof_i;
  assign w_cur_x = w_sof ? '0 : x_q;
  assign w_cur_y = w_sof ? '0 : y_q;
  assign w_win_ok = !cfg_win_en_i ||
                    ((w_cur_x >= cfg_win_ll_x_i) && (w_cur_x <= cfg_win_ur_x_i) &&
                     (w_cur_y >= cfg_win_ll_y_i) && (w_cur_y <= cfg_win_ur_y_i));

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    evt_sof_d   = 1'b0;
    w_push      = 1'b0;
    w_push_data = '0;
    w_acc_base  = acc_q;
    w_lane_base = lane_q;

    if (w_sof) begin
      state_d     = (frame_cnt_q == '0) ? CAPTURE : SKIP;
      evt_sof_d   = (frame_cnt_q == '0);
      frame_cnt_d = (frame_cnt_q == cfg_frame_skip_i) ? '0 : frame_cnt_q + 6'd1;
    end

    // Coordinates are only tracked once a frame has been seen.
    if (pix_valid_i && state_d != IDLE) begin
      if (w_cur_x == cfg_row_len_i) begin
        x_d = '0;
        y_d = (w_cur_y == {CNT_W{1'b1}}) ? w_cur_y : w_cur_y + CNT_W'(1);
      end else begin
        x_d = w_cur_x + CNT_W'(1);
        y_d = w_cur_y;
      end
    end

    if (w_sof && lane_q != 2'd0) begin
      w_push      = 1'b1;
      w_push_data = acc_q;
      w_acc_base  = '0;
      w_lane_base = 2'd0;
    end

    w_keep = pix_valid_i && (state_d == CAPTURE) && w_win_ok;
    w_ins  = w_acc_base;
    if (w_fmt == PIX8) w_ins[{w_lane_base, 3'b000} +: 8]     = pix_data_i[7:0];
    else               w_ins[{w_lane_base[0], 4'b0000} +: 16] = pix_data_i[15:0];

    acc_d  = w_acc_base;
    lane_d = w_lane_base;
    if (w_keep) begin
      if (w_lane_base == cpi_last_lane(w_fmt)) begin
        w_push      = 1'b1;
        w_push_data = w_ins;
        acc_d       = '0;
        lane_d      = 2'd0;
      end else begin
        acc_d  = w_ins;
        lane_d = w_lane_base + 2'd1;
      end
    end

    if (!cfg_en_i) begin
      state_d     = IDLE;
      frame_cnt_d = '0;
      x_d         = '0;
      y_d         = '0;
      acc_d       = '0;
      lane_d      = 2'd0;
      evt_sof_d   = 1'b0;
      w_push      = 1'b0;
    end
  end

  assign w_pop  = !w_empty && ready_i;
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      lane_q      <= 2'd0;
      acc_q       <= '0;
      evt_sof_q   <= 1'b0;
      evt_ovf_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      evt_sof_q   <= evt_sof_d;
      evt_ovf_q   <= w_drop;
      overflow_q  <= cfg_en_i && (overflow_q || w_drop);
    end
  end

  cpi_pack_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (!cfg_en_i),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_pop),
    .data_o  (data_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign valid_o    = !w_empty;
  assign evt_sof_o  = evt_sof_q;
  assign evt_ovf_o  = evt_ovf_q;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_cpi_pixel_packer.sv
// ---------------------------------------------------------------------------
// tb_cpi_pixel_packer : directed self-checking bench for cpi_pixel_packer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpi_pixel_packer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_en_i = 1'b0;
  logic        cfg_fmt_i = 1'b0;
  logic [5:0]  cfg_frame_skip_i = '0;
  logic [15:0] cfg_row_len_i = '0;
  logic        cfg_win_en_i = 1'b0;
  logic [15:0] cfg_win_ll_x_i = '0;
  logic [15:0] cfg_win_ll_y_i = '0;
  logic [15:0] cfg_win_ur_x_i = '0;
  logic [15:0] cfg_win_ur_y_i = '0;
  logic [15:0] pix_data_i = '0;
  logic        pix_valid_i = 1'b0;
  logic        pix_sof_i = 1'b0;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        evt_sof_o;
  logic        evt_ovf_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sof    = 0;
  int n_ovf    = 0;
  logic [31:0] got_q[$];

  always #5 clk_i = ~clk_i;

  cpi_pixel_packer #(
    .FIFO_DEPTH (4),
    .PIX_W      (16),
    .CNT_W      (16)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_fmt_i        (cfg_fmt_i),
    .cfg_frame_skip_i (cfg_frame_skip_i),
    .cfg_row_len_i    (cfg_row_len_i),
    .cfg_win_en_i     (cfg_win_en_i),
    .cfg_win_ll_x_i   (cfg_win_ll_x_i),
    .cfg_win_ll_y_i   (cfg_win_ll_y_i),
    .cfg_win_ur_x_i   (cfg_win_ur_x_i),
    .cfg_win_ur_y_i   (cfg_win_ur_y_i),
    .pix_data_i       (pix_data_i),
    .pix_valid_i      (pix_valid_i),
    .pix_sof_i        (pix_sof_i),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .evt_sof_o        (evt_sof_o),
    .evt_ovf_o        (evt_ovf_o),
    .overflow_o       (overflow_o)
  );

  always @(negedge clk_i) begin
    if (valid_o && ready_i) got_q.push_back(data_o);
    if (evt_sof_o) n_sof++;
    if (evt_ovf_o) n_ovf++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", n_checks);
    $fatal(1);
  end

  task automatic pix(input logic [15:0] d, input logic s);
    pix_data_i  = d;
    pix_valid_i = 1'b1;
    pix_sof_i   = s;
    @(posedge clk_i); #1;
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic setup(input logic fmt, input logic [5:0] skip, input logic [15:0] row,
                       input logic win, input logic [15:0] llx, input logic [15:0] lly,
                       input logic [15:0] urx, input logic [15:0] ury, input logic rdy);
    cfg_en_i = 1'b0;
    cfg_fmt_i = fmt; cfg_frame_skip_i = skip; cfg_row_len_i = row;
    cfg_win_en_i = win; cfg_win_ll_x_i = llx; cfg_win_ll_y_i = lly;
    cfg_win_ur_x_i = urx; cfg_win_ur_y_i = ury;
    ready_i = rdy;
    idle(2);
    cfg_en_i = 1'b1;
    got_q.delete();
    n_sof = 0;
    n_ovf = 0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle(2);
    n_checks++;
    if ({valid_o, evt_sof_o, evt_ovf_o, overflow_o} !== 4'b0000 || data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b sof=%b ovf=%b of=%b d=%h, required all 0",
               valid_o, evt_sof_o, evt_ovf_o, overflow_o, data_o);
    end
    rst_i = 1'b0;
    idle(1);
  endtask

  task automatic test_pack16();
    logic [31:0] exp [4] = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
    setup(1'b0, 6'd0, 16'd3, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    pix(16'h0001, 1'b1);
    for (int i = 2; i <= 8; i++) pix(16'(i), 1'b0);
    idle(5);
    n_checks++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL pack16_count: got %0d words, required 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL pack16_word%0d: got %h, required %h", i,
                 (i < got_q.size()) ? got_q[i] : 32'hx, exp[i]);
      end
    end
    n_checks++;
    if (n_sof != 1) begin
      n_fail++;
      $display("FAIL pack16_sof_pulses: got %0d, required 1", n_sof);
    end
  endtask

  task automatic test_pack8_latency();
    setup(1'b1, 6'd0, 16'd15, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    pix(16'h0011, 1'b1);
    pix(16'h0022, 1'b0);
    pix(16'h0033, 1'b0);
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pack8_early_valid: got %b, required 0", valid_o);
    end
    pix(16'h0044, 1'b0);
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 32'h4433_2211) begin
      n_fail++;
      $display("FAIL pack8_latency: got v=%b d=%h, required v=1 d=44332211", valid_o, data_o);
    end
    ready_i = 1'b1;
    idle(3);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h4433_2211) begin
      n_fail++;
      $display("FAIL pack8_drain: got %0d words, required 1 word 44332211", got_q.size());
    end
  endtask

  task automatic test_window();
    setup(1'b0, 6'd0, 16'd3, 1'b1, 16'd1, 16'd1, 16'd2, 16'd1, 1'b1);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        pix(16'(y * 4 + x), (x == 0 && y == 0));
    idle(5);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h0006_0005) begin
      n_fail++;
      $display("FAIL window_word: got %0d words first=%h, required 1 word 00060005",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
  endtask

  task automatic test_frame_skip();
    setup(1'b0, 6'd2, 16'd15, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    for (int f = 0; f < 6; f++) begin
      pix(16'(f * 2 + 1), 1'b1);
      pix(16'(f * 2 + 2), 1'b0);
    end
    idle(5);
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== 32'h0002_0001 || got_q[1] !== 32'h0008_0007) begin
      n_fail++;
      $display("FAIL skip_words: got %0d words, required 2 words 00020001 00080007", got_q.size());
    end
    n_checks++;
    if (n_sof != 2) begin
      n_fail++;
      $display("FAIL skip_sof_pulses: got %0d, required 2", n_sof);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp [4] = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
    setup(1'b0, 6'd0, 16'd15, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    pix(16'h0001, 1'b1);
    for (int i = 2; i <= 12; i++) pix(16'(i), 1'b0);
    idle(3);
    n_checks++;
    if (n_ovf != 2 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flags: got pulses=%0d sticky=%b, required pulses=2 sticky=1", n_ovf, overflow_o);
    end
    ready_i = 1'b1;
    idle(8);
    n_checks++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d words, required 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL ovf_word%0d: got %h, required %h", i,
                 (i < got_q.size()) ? got_q[i] : 32'hx, exp[i]);
      end
    end
    n_checks++;
    if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after_drain: got v=%b sticky=%b, required v=0 sticky=1", valid_o, overflow_o);
    end
    cfg_en_i = 1'b0;
    idle(1);
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, required 0", overflow_o);
    end
  endtask

  task automatic test_sof_flush_reset();
    setup(1'b1, 6'd0, 16'd15, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    pix(16'h00AA, 1'b1);
    pix(16'h00BB, 1'b0);
    pix(16'h00CC, 1'b0);
    pix(16'h00DD, 1'b1);
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 32'h00CC_BBAA) begin
      n_fail++;
      $display("FAIL sof_flush: got v=%b d=%h, required v=1 d=00CCBBAA", valid_o, data_o);
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b d=%h, required v=0 d=0", valid_o, data_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    ready_i = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) pix(16'(8'h55 + i), 1'b0);
    idle(3);
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_sof: got %0d words, required 0", got_q.size());
    end
    for (int i = 1; i <= 4; i++) pix(16'(i), (i == 1));
    idle(3);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h0403_0201) begin
      n_fail++;
      $display("FAIL reset_new_frame: got %0d words, required 1 word 04030201", got_q.size());
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_pack16();
    test_pack8_latency();
    test_window();
    test_frame_skip();
    test_overflow();
    test_sof_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
